// File: rtl/ct_f_spsram_64x108_ctrl_pkg.sv
// Shared definitions for the 64x108 single-port SRAM access controller:
// geometry defaults, derived data width, FSM state type and the helper
// that turns a per-lane write mask into the active-low bit write enable.
package ct_f_spsram_64x108_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH_D = 6;
    localparam int unsigned WRAP_SIZE_D  = 27;
    localparam int unsigned LANES_D      = 4;
    localparam int unsigned DATA_WIDTH   = LANES_D * WRAP_SIZE_D;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Lane i of the result is all zeros (write) when mask[i]=1, else all ones.
    function automatic logic [DATA_WIDTH-1:0] expand_wmask(input logic [LANES_D-1:0] mask);
        logic [DATA_WIDTH-1:0] wen;
        wen = '1;
        for (int unsigned i = 0; i < LANES_D; i++) begin
            wen[i*WRAP_SIZE_D +: WRAP_SIZE_D] = {WRAP_SIZE_D{~mask[i]}};
        end
        return wen;
    endfunction

endpackage

// File: rtl/ct_f_spsram_64x108_ctrl_if.sv
// Request/response bus of the SRAM access controller.
//   req_vld/req_rdy/req_wr/req_addr/req_wdata/req_wmask : request channel
//   rsp_vld/rsp_rdy/rsp_rdata                            : read response channel
// master = requester, slave = controller.
interface ct_f_spsram_64x108_ctrl_if;
    import ct_f_spsram_64x108_ctrl_pkg::*;

    logic                    req_vld;
    logic                    req_rdy;
    logic                    req_wr;
    logic [ADDR_WIDTH_D-1:0] req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [LANES_D-1:0]      req_wmask;
    logic                    rsp_vld;
    logic                    rsp_rdy;
    logic [DATA_WIDTH-1:0]   rsp_rdata;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata
    );

endinterface

// File: rtl/ct_f_spsram_rsp_fifo.sv
// Two-entry response FIFO holding SRAM read data until the consumer takes it.
//   clk, rst       : clock, synchronous active-high reset (flushes contents)
//   push/push_data : write one entry
//   pop            : drop the head entry
//   head           : current head entry
//   count          : occupancy 0..2
module ct_f_spsram_rsp_fifo #(
    parameter int unsigned DW = 108
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ct_f_spsram_64x108_ctrl.sv
// Access controller for one 64x108 single-port SRAM macro.
//   CLK, RST   : clock, synchronous active-high reset
//   bus        : request/response channel (slave side)
//   init_done  : sticky, high once the post-reset clear sequence is complete
//   sram_*     : macro pins (active-low CEN/GWEN/WEN, address, data in/out)
// After reset every entry is written with zero, then requests are passed
// combinationally to the macro; read data returns through a 2-entry FIFO.
module ct_f_spsram_64x108_ctrl
    import ct_f_spsram_64x108_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_D,
    parameter int unsigned WRAP_SIZE  = WRAP_SIZE_D,
    parameter int unsigned LANES      = LANES_D,
    parameter bit          INIT_EN    = 1'b1
) (
    input  logic                        CLK,
    input  logic                        RST,
    ct_f_spsram_64x108_ctrl_if.slave    bus,
    output logic                        init_done,
    output logic [ADDR_WIDTH-1:0]       sram_a,
    output logic                        sram_cen,
    output logic                        sram_gwen,
    output logic [LANES*WRAP_SIZE-1:0]  sram_wen,
    output logic [LANES*WRAP_SIZE-1:0]  sram_d,
    input  logic [LANES*WRAP_SIZE-1:0]  sram_q
);

    localparam int unsigned DW = LANES * WRAP_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  done_q;
    logic                  inflight;
    logic                  rd_acc;
    logic                  rd_ok;
    logic                  pop;
    logic                  req_rdy_c;
    logic [1:0]            fifo_cnt;
    logic [DW-1:0]         fifo_head;

    // State register, clear counter, completion flag and in-flight read flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= (INIT_EN != 1'b0) ? ST_INIT : ST_RUN;
            init_cnt <= '0;
            done_q   <= 1'b0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            done_q   <= (state_nxt == ST_RUN);
            inflight <= rd_acc;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_cnt == LAST_ADDR) begin
            state_nxt = ST_RUN;
        end
    end

    assign pop = bus.rsp_vld && bus.rsp_rdy;

    // A read needs a free slot for its data, counting the one already in
    // flight; a pop this cycle frees a slot in time for the new data.
    assign rd_ok = (({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd2) || pop;

    // RST gates every output so the macro and bus are quiet even in the
    // first reset cycle, before the registers have been cleared.
    always_comb begin
        req_rdy_c = 1'b0;
        rd_acc    = 1'b0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (!RST) begin
            case (state)
                ST_INIT: begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    sram_a    = init_cnt;
                end
                ST_RUN: begin
                    req_rdy_c = bus.req_wr || rd_ok;
                    if (bus.req_vld && req_rdy_c) begin
                        if (bus.req_wr) begin
                            // An all-zero mask is accepted but never reaches the macro.
                            if (|bus.req_wmask) begin
                                sram_cen  = 1'b0;
                                sram_gwen = 1'b0;
                                sram_wen  = expand_wmask(bus.req_wmask);
                                sram_a    = bus.req_addr;
                                sram_d    = bus.req_wdata;
                            end
                        end else begin
                            rd_acc   = 1'b1;
                            sram_cen = 1'b0;
                            sram_a   = bus.req_addr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    ct_f_spsram_rsp_fifo #(
        .DW (DW)
    ) u_rsp_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (inflight),
        .push_data (sram_q),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    assign bus.req_rdy   = req_rdy_c;
    assign bus.rsp_vld   = !RST && (fifo_cnt != 2'd0);
    assign bus.rsp_rdata = bus.rsp_vld ? fifo_head : '0;
    assign init_done     = done_q && !RST;

endmodule

// File: tb/tb_ct_f_spsram_64x108_ctrl.sv
// Self-checking bench for ct_f_spsram_64x108_ctrl with a behavioural
// 64x108 single-port SRAM attached to the macro pins.
module tb_ct_f_spsram_64x108_ctrl;
    import ct_f_spsram_64x108_ctrl_pkg::*;

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned AW = ADDR_WIDTH_D;
    localparam int unsigned WS = WRAP_SIZE_D;

    localparam logic [DW-1:0] D1     = 108'h123456789ABCDEF0123456789;
    localparam logic [DW-1:0] ONES   = '1;
    localparam logic [DW-1:0] ZERO   = '0;
    localparam logic [DW-1:0] PAT    = {27'h7FFFFFF, 27'h0, 27'h7FFFFFF, 27'h0};
    localparam logic [DW-1:0] W9     = {4{27'h2AAAAAA}};
    localparam logic [DW-1:0] L3     = {27'h2AAAAAA, 81'h0};
    localparam logic [DW-1:0] WEN_M8 = {27'h0, {81{1'b1}}};
    localparam logic [DW-1:0] JUNK   = {4{27'h5A5A5A5}};

    typedef struct {
        logic          vld;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wmask;
        logic          e_rdy;
        logic          e_cen;
        logic          e_gwen;
        logic [DW-1:0] e_wen;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        logic [DW-1:0] e_rsp;
    } vec_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q = '0;
    logic          mem_fill = 1'b1;
    logic          mon_en = 1'b0;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] exp_mem [64];
    logic [DW-1:0] exp_q [$];
    vec_t          vt [10];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    ct_f_spsram_64x108_ctrl_if bus ();

    ct_f_spsram_64x108_ctrl #(
        .ADDR_WIDTH (AW),
        .WRAP_SIZE  (WS),
        .LANES      (LANES_D),
        .INIT_EN    (1'b1)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .init_done (init_done),
        .sram_a    (sram_a),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    // Behavioural macro: bit-masked write, registered read, junk preload.
    always @(posedge CLK) begin
        if (mem_fill) begin
            for (int i = 0; i < 64; i++) mem[i] <= JUNK;
        end else if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= mem[sram_a];
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor used while the vector table runs.
    always @(posedge CLK) begin
        #2;
        if (mon_en && bus.rsp_vld && bus.rsp_rdy) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL mon_unexpected: got %h expected no response", bus.rsp_rdata);
            end else begin
                chk("mon_rsp", bus.rsp_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_in();
        bus.req_vld   = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
    endtask

    task automatic set_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
        bus.req_vld   = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
    endtask

    task automatic note_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
        for (int l = 0; l < 4; l++) begin
            if (m[l]) exp_mem[a][l*WS +: WS] = d[l*WS +: WS];
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        nxt();
        set_req(1'b1, a, d, 4'hF);
        settle();
        chk("wr_rdy", DW'(bus.req_rdy), DW'(1'b1));
        note_write(a, d, 4'hF);
    endtask

    // Called at the check point of a cycle; waits a bounded number of cycles.
    task automatic expect_rsp(input string name, input logic [DW-1:0] exp);
        bit found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.rsp_vld) begin
                chk(name, bus.rsp_rdata, exp);
                found = 1'b1;
                break;
            end
            nxt();
            settle();
        end
        if (!found) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no rsp_vld expected %h", name, exp);
        end
    endtask

    function automatic vec_t mk(input logic vld, input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [3:0] wmask,
                                input logic e_rdy, input logic e_cen, input logic e_gwen,
                                input logic [DW-1:0] e_wen, input logic [AW-1:0] e_a,
                                input logic [DW-1:0] e_d, input logic [DW-1:0] e_rsp);
        vec_t v;
        v.vld = vld; v.wr = wr; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
        v.e_rdy = e_rdy; v.e_cen = e_cen; v.e_gwen = e_gwen; v.e_wen = e_wen;
        v.e_a = e_a; v.e_d = e_d; v.e_rsp = e_rsp;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1);
    end

    initial begin
        //          vld  wr   addr   wdata  mask   rdy  cen  gwen wen     a      d     rsp
        vt[0] = mk(1'b1, 1'b1, 6'd5,  D1,   4'hF,  1'b1, 1'b0, 1'b0, ZERO,   6'd5,  D1,   ZERO);
        vt[1] = mk(1'b1, 1'b0, 6'd5,  ONES, 4'hF,  1'b1, 1'b0, 1'b1, ONES,   6'd5,  ZERO, D1);
        vt[2] = mk(1'b1, 1'b1, 6'd7,  ONES, 4'hF,  1'b1, 1'b0, 1'b0, ZERO,   6'd7,  ONES, ZERO);
        vt[3] = mk(1'b1, 1'b1, 6'd7,  ZERO, 4'h5,  1'b1, 1'b0, 1'b0, PAT,    6'd7,  ZERO, ZERO);
        vt[4] = mk(1'b1, 1'b0, 6'd7,  ZERO, 4'h0,  1'b1, 1'b0, 1'b1, ONES,   6'd7,  ZERO, PAT);
        vt[5] = mk(1'b0, 1'b1, 6'd12, ONES, 4'hF,  1'b1, 1'b1, 1'b1, ONES,   6'd0,  ZERO, ZERO);
        vt[6] = mk(1'b1, 1'b1, 6'd9,  W9,   4'h8,  1'b1, 1'b0, 1'b0, WEN_M8, 6'd9,  W9,   ZERO);
        vt[7] = mk(1'b1, 1'b1, 6'd9,  ONES, 4'h0,  1'b1, 1'b1, 1'b1, ONES,   6'd0,  ZERO, ZERO);
        vt[8] = mk(1'b1, 1'b0, 6'd9,  ZERO, 4'h0,  1'b1, 1'b0, 1'b1, ONES,   6'd9,  ZERO, L3);
        vt[9] = mk(1'b1, 1'b0, 6'd5,  ZERO, 4'h0,  1'b1, 1'b0, 1'b1, ONES,   6'd5,  ZERO, D1);

        for (int i = 0; i < 64; i++) exp_mem[i] = '0;
        idle_in();
        bus.rsp_rdy = 1'b0;

        // Reset state
        nxt();
        nxt();
        settle();
        chk("rst_req_rdy",   DW'(bus.req_rdy), DW'(1'b0));
        chk("rst_rsp_vld",   DW'(bus.rsp_vld), DW'(1'b0));
        chk("rst_rsp_rdata", bus.rsp_rdata, ZERO);
        chk("rst_init_done", DW'(init_done), DW'(1'b0));
        chk("rst_ctl",       DW'({sram_cen, sram_gwen, sram_a}), DW'({1'b1, 1'b1, 6'd0}));
        chk("rst_wen",       sram_wen, ONES);
        chk("rst_d",         sram_d, ZERO);
        mem_fill = 1'b0;

        // Clear sequence: 64 write cycles to addresses 0..63
        nxt();
        RST = 1'b0;
        for (int k = 0; k < 64; k++) begin
            settle();
            chk("init_ctl", DW'({sram_cen, sram_gwen, bus.req_rdy, init_done, sram_a}),
                DW'({4'b0000, 6'(k)}));
            chk("init_wen", sram_wen, ZERO);
            chk("init_d", sram_d, ZERO);
            nxt();
        end
        settle();
        chk("init_done_64", DW'(init_done), DW'(1'b1));
        chk("run_req_rdy",  DW'(bus.req_rdy), DW'(1'b1));
        chk("run_idle_cen", DW'(sram_cen), DW'(1'b1));

        // Read of the last cleared entry, with exact latency
        bus.rsp_rdy = 1'b1;
        nxt();
        set_req(1'b0, 6'd63, ZERO, 4'h0);
        settle();
        chk("rd63_accept", DW'({bus.req_rdy, sram_cen, sram_gwen, sram_a}),
            DW'({1'b1, 1'b0, 1'b1, 6'd63}));
        nxt();
        idle_in();
        settle();
        chk("rd63_vld_n1", DW'(bus.rsp_vld), DW'(1'b0));
        nxt();
        settle();
        chk("rd63_vld_n2", DW'(bus.rsp_vld), DW'(1'b1));
        chk("rd63_data",   bus.rsp_rdata, ZERO);
        nxt();
        settle();
        chk("rd63_popped", DW'(bus.rsp_vld), DW'(1'b0));

        // Vector table: SRAM-side decode checked per cycle, responses by monitor
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nxt();
            if (vt[i].vld) set_req(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].wmask);
            else begin
                idle_in();
                bus.req_wr    = vt[i].wr;
                bus.req_addr  = vt[i].addr;
                bus.req_wdata = vt[i].wdata;
                bus.req_wmask = vt[i].wmask;
            end
            settle();
            chk("tbl_rdy",  DW'(bus.req_rdy), DW'(vt[i].e_rdy));
            chk("tbl_cen",  DW'(sram_cen),    DW'(vt[i].e_cen));
            chk("tbl_gwen", DW'(sram_gwen),   DW'(vt[i].e_gwen));
            chk("tbl_wen",  sram_wen,         vt[i].e_wen);
            chk("tbl_a",    DW'(sram_a),      DW'(vt[i].e_a));
            chk("tbl_d",    sram_d,           vt[i].e_d);
            if (vt[i].vld && vt[i].wr) note_write(vt[i].addr, vt[i].wdata, vt[i].wmask);
            if (vt[i].vld && !vt[i].wr) exp_q.push_back(vt[i].e_rsp);
        end
        nxt();
        idle_in();
        for (int j = 0; j < 10; j++) begin
            if (exp_q.size() == 0) break;
            nxt();
        end
        chk("tbl_drain", DW'(exp_q.size()), ZERO);
        mon_en = 1'b0;

        // Backpressure: third read stalls until a pop frees a slot
        do_write(6'd1, 108'h0A1A1);
        do_write(6'd2, 108'h0B2B2B2);
        do_write(6'd3, 108'h0C3C3C3C3);
        bus.rsp_rdy = 1'b0;
        nxt();
        set_req(1'b0, 6'd1, ZERO, 4'h0);
        settle();
        chk("bp_rd1_rdy", DW'(bus.req_rdy), DW'(1'b1));
        nxt();
        set_req(1'b0, 6'd2, ZERO, 4'h0);
        settle();
        chk("bp_rd2_rdy", DW'(bus.req_rdy), DW'(1'b1));
        nxt();
        set_req(1'b0, 6'd3, ZERO, 4'h0);
        settle();
        chk("bp_rd3_rdy", DW'(bus.req_rdy), DW'(1'b0));
        nxt();
        settle();
        chk("bp_hold_rdy", DW'(bus.req_rdy), DW'(1'b0));
        chk("bp_hold_vld", DW'(bus.rsp_vld), DW'(1'b1));
        nxt();
        bus.rsp_rdy = 1'b1;
        settle();
        chk("bp_credit_rdy", DW'(bus.req_rdy), DW'(1'b1));
        chk("bp_rsp1", bus.rsp_rdata, exp_mem[1]);
        nxt();
        idle_in();
        settle();
        expect_rsp("bp_rsp2", exp_mem[2]);
        nxt();
        settle();
        expect_rsp("bp_rsp3", exp_mem[3]);
        nxt();
        settle();
        chk("bp_empty", DW'(bus.rsp_vld), DW'(1'b0));

        // Streaming: 64 back-to-back reads with the consumer always ready
        for (int k = 0; k < 68; k++) begin
            nxt();
            if (k < 64) set_req(1'b0, 6'(k), ZERO, 4'h0);
            else        idle_in();
            settle();
            if (k < 64) chk("stream_rdy", DW'(bus.req_rdy), DW'(1'b1));
            chk("stream_vld", DW'(bus.rsp_vld), DW'((k >= 2 && k < 66) ? 1'b1 : 1'b0));
            if (k >= 2 && k < 66) chk("stream_data", bus.rsp_rdata, exp_mem[k-2]);
        end

        // Reset while a response is held in the buffer
        bus.rsp_rdy = 1'b0;
        nxt();
        set_req(1'b0, 6'd5, ZERO, 4'h0);
        nxt();
        idle_in();
        nxt();
        settle();
        chk("mid_held_vld", DW'(bus.rsp_vld), DW'(1'b1));
        nxt();
        RST = 1'b1;
        settle();
        chk("mid_rst_cen", DW'({sram_cen, bus.rsp_vld, bus.req_rdy}), DW'({1'b1, 1'b0, 1'b0}));
        nxt();
        RST = 1'b0;
        settle();
        chk("mid_rsp_vld",   DW'(bus.rsp_vld), DW'(1'b0));
        chk("mid_init_a0",   DW'({sram_cen, sram_gwen, sram_a}), DW'({1'b0, 1'b0, 6'd0}));
        chk("mid_init_done", DW'(init_done), DW'(1'b0));
        nxt();
        settle();
        chk("mid_init_a1",   DW'(sram_a), DW'(6'd1));
        chk("mid_rsp_vld2",  DW'(bus.rsp_vld), DW'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
